spi_arbiter: RTL and testbench

Sequencer/arbiter sharing one `z80_spimaster` between two on-chip requesters (e.g. SD-card block reader and boot loader). Drives the master's Z80-style register bus itself: config write (chip select + hold), data write, busy polling, data read. Performs full-duplex bursts of 1–256 bytes per grant, round-robin between requesters. Sits beside the CPU-side bus mux that selects between arbiter and Z80 access to the SPI master.

---
 rtl/spi_arbiter_if.sv | 28 ++
 rtl/spi_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Z80-style register bus between the arbiter and one z80_spimaster.
// The arbiter drives the strobes, address and write data; the master returns read data.
interface spi_arbiter_if;
    logic       m_iorq_L;
    logic       m_rd_L;
    logic       m_wr_L;
    logic       m_a;
    logic [7:0] m_d;
    logic [7:0] m_d_in;

    modport master (
        output m_iorq_L,
        output m_rd_L,
        output m_wr_L,
        output m_a,
        output m_d,
        input  m_d_in
    );

    modport slave (
        input  m_iorq_L,
        input  m_rd_L,
        input  m_wr_L,
        input  m_a,
        input  m_d,
        output m_d_in
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one z80_spimaster between two requesters; runs
// 1-256 byte full-duplex bursts by driving the master's register bus directly.
// TX handshake: the owner holds tx_valid/tx_data until it sees the one-cycle
// tx_ack, which follows the TXWAIT cycle in which tx_valid was sampled high.
module spi_arbiter #(
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] req0_cs,
    input  logic [4:0] req0_mode,
    input  logic [7:0] req0_len,
    input  logic       req0_tx_valid,
    input  logic [7:0] req0_tx_data,
    output logic       req0_tx_ack,
    output logic       req0_rx_valid,
    output logic       req0_grant,
    output logic       req0_done,
    output logic       req0_err,
    input  logic       req1,
    input  logic [1:0] req1_cs,
    input  logic [4:0] req1_mode,
    input  logic [7:0] req1_len,
    input  logic       req1_tx_valid,
    input  logic [7:0] req1_tx_data,
    output logic       req1_tx_ack,
    output logic       req1_rx_valid,
    output logic       req1_grant,
    output logic       req1_done,
    output logic       req1_err,
    output logic [7:0] rx_data,
    spi_arbiter_if.master bus,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CFG     = 4'd1,
        S_TXWAIT  = 4'd2,
        S_WR      = 4'd3,
        S_SETTLE  = 4'd4,
        S_POLL    = 4'd5,
        S_RD      = 4'd6,
        S_RELEASE = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    localparam logic [11:0] TMO = 12'(TIMEOUT);

    state_t      state_q;
    logic        rr_q;
    logic        own_q;
    logic [1:0]  cs_q;
    logic [4:0]  mode_q;
    logic [8:0]  cnt_q;
    logic [11:0] tmo_q;
    logic        err_flag_q;
    logic [1:0]  grant_q;
    logic [1:0]  tx_ack_q;
    logic [1:0]  rx_valid_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic [7:0]  rx_data_q;
    logic        iorq_l_q;
    logic        rd_l_q;
    logic        wr_l_q;
    logic        a_q;
    logic [7:0]  d_q;

    logic        any_req;
    logic        pick;
    logic [1:0]  sel_cs;
    logic [4:0]  sel_mode;
    logic [7:0]  sel_len;
    logic [1:0]  own_mask;
    logic        own_tx_valid;
    logic [7:0]  own_tx_data;
    logic [11:0] tmo_inc;

    always_comb begin
        any_req      = req0 | req1;
        // rr holds priority; fall back to the other side when it is not requesting
        pick         = rr_q ? req1 : ~req0;
        sel_cs       = pick ? req1_cs   : req0_cs;
        sel_mode     = pick ? req1_mode : req0_mode;
        sel_len      = pick ? req1_len  : req0_len;
        own_mask     = own_q ? 2'b10 : 2'b01;
        own_tx_valid = own_q ? req1_tx_valid : req0_tx_valid;
        own_tx_data  = own_q ? req1_tx_data  : req0_tx_data;
        tmo_inc      = tmo_q + 12'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            own_q      <= 1'b0;
            cs_q       <= 2'd0;
            mode_q     <= 5'd0;
            cnt_q      <= 9'd0;
            tmo_q      <= 12'd0;
            err_flag_q <= 1'b0;
            grant_q    <= 2'b00;
            tx_ack_q   <= 2'b00;
            rx_valid_q <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rx_data_q  <= 8'd0;
            iorq_l_q   <= 1'b1;
            rd_l_q     <= 1'b1;
            wr_l_q     <= 1'b1;
            a_q        <= 1'b0;
            d_q        <= 8'd0;
        end else begin
            // Bus outputs describe the access of the state being entered
            tx_ack_q   <= 2'b00;
            rx_valid_q <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            iorq_l_q   <= 1'b1;
            rd_l_q     <= 1'b1;
            wr_l_q     <= 1'b1;
            a_q        <= 1'b0;
            d_q        <= 8'd0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        own_q      <= pick;
                        grant_q    <= pick ? 2'b10 : 2'b01;
                        cs_q       <= sel_cs;
                        mode_q     <= sel_mode;
                        cnt_q      <= (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
                        err_flag_q <= 1'b0;
                        iorq_l_q   <= 1'b0;
                        wr_l_q     <= 1'b0;
                        a_q        <= 1'b1;
                        d_q        <= {1'b1, sel_cs, sel_mode};
                        state_q    <= S_CFG;
                    end
                end
                S_CFG: state_q <= S_TXWAIT;
                S_TXWAIT: begin
                    if (own_tx_valid) begin
                        tx_ack_q <= own_mask;
                        iorq_l_q <= 1'b0;
                        wr_l_q   <= 1'b0;
                        d_q      <= own_tx_data;
                        state_q  <= S_WR;
                    end
                end
                S_WR: state_q <= S_SETTLE;
                S_SETTLE: begin
                    tmo_q    <= 12'd0;
                    iorq_l_q <= 1'b0;
                    rd_l_q   <= 1'b0;
                    a_q      <= 1'b1;
                    state_q  <= S_POLL;
                end
                S_POLL: begin
                    if (bus.m_d_in[7]) begin
                        tmo_q <= tmo_inc;
                        if (tmo_inc == TMO) begin
                            err_flag_q <= 1'b1;
                            iorq_l_q   <= 1'b0;
                            wr_l_q     <= 1'b0;
                            a_q        <= 1'b1;
                            d_q        <= {1'b0, cs_q, mode_q};
                            state_q    <= S_RELEASE;
                        end else begin
                            iorq_l_q <= 1'b0;
                            rd_l_q   <= 1'b0;
                            a_q      <= 1'b1;
                        end
                    end else begin
                        iorq_l_q <= 1'b0;
                        rd_l_q   <= 1'b0;
                        state_q  <= S_RD;
                    end
                end
                S_RD: begin
                    rx_data_q  <= bus.m_d_in;
                    rx_valid_q <= own_mask;
                    cnt_q      <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        iorq_l_q <= 1'b0;
                        wr_l_q   <= 1'b0;
                        a_q      <= 1'b1;
                        d_q      <= {1'b0, cs_q, mode_q};
                        state_q  <= S_RELEASE;
                    end else begin
                        state_q <= S_TXWAIT;
                    end
                end
                S_RELEASE: begin
                    if (err_flag_q) begin
                        err_q <= own_mask;
                    end else begin
                        done_q <= own_mask;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    grant_q <= 2'b00;
                    rr_q    <= ~own_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_grant    = grant_q[0];
    assign req1_grant    = grant_q[1];
    assign req0_tx_ack   = tx_ack_q[0];
    assign req1_tx_ack   = tx_ack_q[1];
    assign req0_rx_valid = rx_valid_q[0];
    assign req1_rx_valid = rx_valid_q[1];
    assign req0_done     = done_q[0];
    assign req1_done     = done_q[1];
    assign req0_err      = err_q[0];
    assign req1_err      = err_q[1];
    assign rx_data       = rx_data_q;
    assign bus.m_iorq_L  = iorq_l_q;
    assign bus.m_rd_L    = rd_l_q;
    assign bus.m_wr_L    = wr_l_q;
    assign bus.m_a       = a_q;
    assign bus.m_d       = d_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a small busy-flag model of the SPI master,
// a per-cycle bus/requester monitor, and one task per scenario.
module tb_spi_arbiter;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req0, req1;
    logic [1:0] req0_cs, req1_cs;
    logic [4:0] req0_mode, req1_mode;
    logic [7:0] req0_len, req1_len;
    logic       req0_tx_valid, req1_tx_valid;
    logic [7:0] req0_tx_data, req1_tx_data;
    logic       req0_tx_ack, req0_rx_valid, req0_grant, req0_done, req0_err;
    logic       req1_tx_ack, req1_rx_valid, req1_grant, req1_done, req1_err;
    logic [7:0] rx_data;
    logic [3:0] state_o;

    spi_arbiter_if bus_if ();

    spi_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req0_cs(req0_cs), .req0_mode(req0_mode), .req0_len(req0_len),
        .req0_tx_valid(req0_tx_valid), .req0_tx_data(req0_tx_data),
        .req0_tx_ack(req0_tx_ack), .req0_rx_valid(req0_rx_valid), .req0_grant(req0_grant),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1(req1), .req1_cs(req1_cs), .req1_mode(req1_mode), .req1_len(req1_len),
        .req1_tx_valid(req1_tx_valid), .req1_tx_data(req1_tx_data),
        .req1_tx_ack(req1_tx_ack), .req1_rx_valid(req1_rx_valid), .req1_grant(req1_grant),
        .req1_done(req1_done), .req1_err(req1_err),
        .rx_data(rx_data), .bus(bus_if.master), .state_o(state_o)
    );

    // SPI master model: busy for busy_len clocks after each data write
    int         busy_len = 0;
    bit         busy_stuck = 1'b0;
    bit         loopback = 1'b0;
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] mosi_last = 8'h00;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        if (!bus_if.m_iorq_L && !bus_if.m_wr_L && !bus_if.m_a) begin
            busy_cnt  <= busy_len;
            mosi_last <= bus_if.m_d;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign bus_if.m_d_in = bus_if.m_a ? {(busy_stuck || busy_cnt != 0), 7'd0}
                                      : (loopback ? mosi_last : miso_byte);

    int n_tests = 0;
    int n_fail = 0;

    int n_poll, n_rd, strobe_bad, nonown_bad, n_rx_bad;
    int n_ack0, n_ack1, n_rxv0, n_rxv1, n_done0, n_done1, n_err0, n_err1;
    logic [7:0] cfg_log[$];
    logic [7:0] dw_log[$];
    logic [7:0] exp_q[$];
    int grant_log[$];
    logic g0_prev = 1'b0;
    logic g1_prev = 1'b0;
    logic [7:0] step0 = 8'd1;
    logic [7:0] step1 = 8'd1;

    task automatic clear_logs();
        n_poll = 0; n_rd = 0; strobe_bad = 0; nonown_bad = 0; n_rx_bad = 0;
        n_ack0 = 0; n_ack1 = 0; n_rxv0 = 0; n_rxv1 = 0;
        n_done0 = 0; n_done1 = 0; n_err0 = 0; n_err1 = 0;
        cfg_log.delete(); dw_log.delete(); exp_q.delete(); grant_log.delete();
    endtask

    // Advance one cycle, record bus accesses and requester pulses, feed TX bytes
    task automatic step_cycle();
        logic [7:0] e;
        @(negedge clk);
        if (!bus_if.m_iorq_L) begin
            if (bus_if.m_rd_L == bus_if.m_wr_L) strobe_bad++;
            if (!bus_if.m_wr_L && bus_if.m_a) cfg_log.push_back(bus_if.m_d);
            if (!bus_if.m_wr_L && !bus_if.m_a) dw_log.push_back(bus_if.m_d);
            if (!bus_if.m_rd_L && bus_if.m_a) n_poll++;
            if (!bus_if.m_rd_L && !bus_if.m_a) n_rd++;
        end else if (!bus_if.m_rd_L || !bus_if.m_wr_L) begin
            strobe_bad++;
        end
        if (req0_grant && req1_grant) nonown_bad++;
        if (!req0_grant && (req0_tx_ack || req0_rx_valid || req0_done || req0_err)) nonown_bad++;
        if (!req1_grant && (req1_tx_ack || req1_rx_valid || req1_done || req1_err)) nonown_bad++;
        if (req0_grant && !g0_prev) grant_log.push_back(0);
        if (req1_grant && !g1_prev) grant_log.push_back(1);
        g0_prev = req0_grant;
        g1_prev = req1_grant;
        if (req0_tx_ack) n_ack0++;
        if (req1_tx_ack) n_ack1++;
        if (req0_rx_valid) n_rxv0++;
        if (req1_rx_valid) n_rxv1++;
        if (req0_done) n_done0++;
        if (req1_done) n_done1++;
        if (req0_err) n_err0++;
        if (req1_err) n_err1++;
        if ((req0_rx_valid || req1_rx_valid) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rx_data !== e) n_rx_bad++;
        end
        if (req0_tx_ack) req0_tx_data = req0_tx_data + step0;
        if (req1_tx_ack) req1_tx_data = req1_tx_data + step1;
    endtask

    task automatic wait_end(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            step_cycle();
            if (req0_done || req1_done || req0_err || req1_err) ok = 1'b1;
        end
        step_cycle();
        step_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step_cycle();
        step_cycle();
        n_tests++;
        if (bus_if.m_iorq_L !== 1'b1 || bus_if.m_rd_L !== 1'b1 || bus_if.m_wr_L !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_strobes: got iorq=%b rd=%b wr=%b, want 1 1 1",
                     bus_if.m_iorq_L, bus_if.m_rd_L, bus_if.m_wr_L);
        end
        n_tests++;
        if (bus_if.m_a !== 1'b0 || bus_if.m_d !== 8'h00 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got a=%b d=%h rx=%h, want 0 00 00", bus_if.m_a, bus_if.m_d, rx_data);
        end
        n_tests++;
        if ({req0_grant, req1_grant, req0_tx_ack, req1_tx_ack, req0_rx_valid, req1_rx_valid,
             req0_done, req1_done, req0_err, req1_err} !== 10'd0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got state=%0d, outputs not all 0, want IDLE and 0", state_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        busy_len = 8; miso_byte = 8'h5A;
        req0_cs = 2'd2; req0_mode = 5'h03; req0_len = 8'd1;
        req0_tx_data = 8'hA7; step0 = 8'd1; req0_tx_valid = 1'b1;
        req0 = 1'b1;
        step_cycle();
        n_tests++;
        if (req0_grant !== 1'b1 || bus_if.m_iorq_L !== 1'b0 || bus_if.m_d !== 8'hC3 || bus_if.m_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant_latency: got grant=%b iorq=%b d=%h a=%b, want 1 0 c3 1",
                     req0_grant, bus_if.m_iorq_L, bus_if.m_d, bus_if.m_a);
        end
        req0 = 1'b0;
        wait_end(200, ok);
        req0_tx_valid = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: got no done, want done0"); end
        n_tests++;
        if (cfg_log.size() != 2 || cfg_log[0] !== 8'hC3 || cfg_log[1] !== 8'h43) begin
            n_fail++;
            $display("FAIL single_cfg_writes: got %0d writes, want c3 then 43", cfg_log.size());
        end
        n_tests++;
        if (dw_log.size() != 1 || dw_log[0] !== 8'hA7) begin
            n_fail++;
            $display("FAIL single_data_write: got %0d writes, want one a7", dw_log.size());
        end
        n_tests++;
        if (n_poll != 8 || n_rd != 1) begin
            n_fail++;
            $display("FAIL single_poll_rd: got polls=%0d rds=%0d, want 8 1", n_poll, n_rd);
        end
        n_tests++;
        if (n_done0 != 1 || n_err0 != 0 || n_ack0 != 1 || n_rxv0 != 1) begin
            n_fail++;
            $display("FAIL single_pulses: got done=%0d err=%0d ack=%0d rxv=%0d, want 1 0 1 1",
                     n_done0, n_err0, n_ack0, n_rxv0);
        end
        n_tests++;
        if (rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_rx_data: got %h, want 5a", rx_data);
        end
        n_tests++;
        if (strobe_bad != 0 || nonown_bad != 0 || req0_grant !== 1'b0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL single_end_state: got strobe_bad=%0d nonown_bad=%0d grant=%b state=%0d, want 0 0 0 0",
                     strobe_bad, nonown_bad, req0_grant, state_o);
        end
    endtask

    task automatic test_reset_mid_poll();
        bit ok;
        bit reached;
        clear_logs();
        busy_stuck = 1'b1;
        req0_cs = 2'd0; req0_mode = 5'h00; req0_len = 8'd1;
        req0_tx_data = 8'h11; req0_tx_valid = 1'b1;
        req0 = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step_cycle();
            if (state_o == 4'd5) reached = 1'b1;
        end
        n_tests++;
        if (!reached) begin n_fail++; $display("FAIL midpoll_reach: got state=%0d, want POLL", state_o); end
        req0 = 1'b0;
        reset = 1'b1;
        step_cycle();
        n_tests++;
        if (bus_if.m_iorq_L !== 1'b1 || bus_if.m_rd_L !== 1'b1 || bus_if.m_wr_L !== 1'b1 ||
            req0_grant !== 1'b0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL midpoll_abort: got iorq=%b rd=%b wr=%b grant=%b state=%0d, want 1 1 1 0 0",
                     bus_if.m_iorq_L, bus_if.m_rd_L, bus_if.m_wr_L, req0_grant, state_o);
        end
        reset = 1'b0;
        busy_stuck = 1'b0;
        busy_len = 2;
        step_cycle();
        n_tests++;
        if (cfg_log.size() != 1) begin
            n_fail++;
            $display("FAIL midpoll_no_release: got %0d config writes, want 1", cfg_log.size());
        end
        clear_logs();
        req0 = 1'b1;
        step_cycle();
        req0 = 1'b0;
        wait_end(200, ok);
        req0_tx_valid = 1'b0;
        n_tests++;
        if (!ok || n_done0 != 1 || n_poll != 2 || cfg_log.size() != 2) begin
            n_fail++;
            $display("FAIL midpoll_recover: got ok=%0d done=%0d polls=%0d cfgw=%0d, want 1 1 2 2",
                     ok, n_done0, n_poll, cfg_log.size());
        end
    endtask

    task automatic test_loopback();
        bit ok;
        clear_logs();
        loopback = 1'b1; busy_len = 1;
        req1_cs = 2'd1; req1_mode = 5'h1F; req1_len = 8'd0;
        req1_tx_data = 8'h10; step1 = 8'd7;
        for (int k = 0; k < 256; k++) exp_q.push_back(8'(16 + 7 * k));
        req1_tx_valid = 1'b1;
        req1 = 1'b1;
        step_cycle();
        req1 = 1'b0;
        wait_end(3000, ok);
        req1_tx_valid = 1'b0;
        loopback = 1'b0;
        n_tests++;
        if (!ok || n_done1 != 1 || n_done0 != 0 || n_err1 != 0) begin
            n_fail++;
            $display("FAIL loop_done: got ok=%0d done1=%0d done0=%0d err1=%0d, want 1 1 0 0",
                     ok, n_done1, n_done0, n_err1);
        end
        n_tests++;
        if (n_ack1 != 256 || n_rxv1 != 256 || dw_log.size() != 256) begin
            n_fail++;
            $display("FAIL loop_counts: got ack=%0d rxv=%0d writes=%0d, want 256 256 256",
                     n_ack1, n_rxv1, dw_log.size());
        end
        n_tests++;
        if (exp_q.size() != 0 || n_rx_bad != 0) begin
            n_fail++;
            $display("FAIL loop_rx_bytes: got left=%0d bad=%0d, want 0 0", exp_q.size(), n_rx_bad);
        end
        n_tests++;
        if (cfg_log.size() != 2 || cfg_log[0] !== 8'hBF || cfg_log[1] !== 8'h3F || nonown_bad != 0) begin
            n_fail++;
            $display("FAIL loop_cfg: got %0d config writes nonown_bad=%0d, want bf 3f and 0",
                     cfg_log.size(), nonown_bad);
        end
    endtask

    task automatic test_round_robin();
        bit fin;
        clear_logs();
        busy_len = 0;
        req0_len = 8'd1; req1_len = 8'd1;
        req0_tx_valid = 1'b1; req1_tx_valid = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            step_cycle();
            if (n_done0 + n_done1 == 4) fin = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        step_cycle();
        step_cycle();
        step_cycle();
        req0_tx_valid = 1'b0; req1_tx_valid = 1'b0;
        n_tests++;
        if (!fin || n_done0 != 2 || n_done1 != 2) begin
            n_fail++;
            $display("FAIL rr_done: got fin=%0d done0=%0d done1=%0d, want 1 2 2", fin, n_done0, n_done1);
        end
        n_tests++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
            grant_log[2] != 0 || grant_log[3] != 1) begin
            n_fail++;
            $display("FAIL rr_order: got %0d grants, want order 0 1 0 1", grant_log.size());
        end
        n_tests++;
        if (nonown_bad != 0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL rr_exclusive: got nonown_bad=%0d state=%0d, want 0 0", nonown_bad, state_o);
        end
    endtask

    task automatic test_txwait_stall();
        bit ok;
        bit reached;
        int low_cnt;
        int nogrant_cnt;
        clear_logs();
        busy_len = 0;
        req0_cs = 2'd3; req0_mode = 5'h0A; req0_len = 8'd1;
        req0_tx_data = 8'h3C; req0_tx_valid = 1'b0;
        req0 = 1'b1;
        step_cycle();
        req0 = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            step_cycle();
            if (state_o == 4'd2) reached = 1'b1;
        end
        low_cnt = 0;
        nogrant_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            if (!bus_if.m_iorq_L || !bus_if.m_rd_L || !bus_if.m_wr_L) low_cnt++;
            if (!req0_grant) nogrant_cnt++;
        end
        n_tests++;
        if (!reached || low_cnt != 0 || nogrant_cnt != 0) begin
            n_fail++;
            $display("FAIL stall_idle_bus: got reached=%0d strobes=%0d nogrant=%0d, want 1 0 0",
                     reached, low_cnt, nogrant_cnt);
        end
        n_tests++;
        if (cfg_log.size() != 1 || cfg_log[0] !== 8'hEA) begin
            n_fail++;
            $display("FAIL stall_cs_held: got %0d config writes, want only ea", cfg_log.size());
        end
        req0_tx_valid = 1'b1;
        wait_end(100, ok);
        req0_tx_valid = 1'b0;
        n_tests++;
        if (!ok || n_done0 != 1 || dw_log.size() != 1 || cfg_log.size() != 2 || cfg_log[1] !== 8'h6A) begin
            n_fail++;
            $display("FAIL stall_resume: got ok=%0d done=%0d writes=%0d cfgw=%0d, want 1 1 1 2 ending 6a",
                     ok, n_done0, dw_log.size(), cfg_log.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        busy_stuck = 1'b1;
        req0_cs = 2'd1; req0_mode = 5'h10; req0_len = 8'd2;
        req0_tx_data = 8'h55; req0_tx_valid = 1'b1;
        req0 = 1'b1;
        step_cycle();
        req0 = 1'b0;
        wait_end(200, ok);
        req0_tx_valid = 1'b0;
        busy_stuck = 1'b0;
        n_tests++;
        if (!ok || n_poll != TMO || n_rd != 0) begin
            n_fail++;
            $display("FAIL timeout_polls: got ok=%0d polls=%0d rds=%0d, want 1 %0d 0", ok, n_poll, n_rd, TMO);
        end
        n_tests++;
        if (n_err0 != 1 || n_done0 != 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err=%0d done=%0d, want 1 0", n_err0, n_done0);
        end
        n_tests++;
        if (cfg_log.size() != 2 || cfg_log[0] !== 8'hB0 || cfg_log[1] !== 8'h30 || req0_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: got %0d config writes grant=%b, want b0 30 and 0",
                     cfg_log.size(), req0_grant);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        req0_cs = 2'd0; req1_cs = 2'd0;
        req0_mode = 5'd0; req1_mode = 5'd0;
        req0_len = 8'd1; req1_len = 8'd1;
        req0_tx_valid = 1'b0; req1_tx_valid = 1'b0;
        req0_tx_data = 8'd0; req1_tx_data = 8'd0;
        clear_logs();
        test_reset();
        test_single();
        test_reset_mid_poll();
        test_loopback();
        test_round_robin();
        test_txwait_stall();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
